// File: rtl/spi_axi_bridge_master.sv
// SPI-slave frame decoder driving single-beat AXI4 reads/writes.
// Oversamples SPI pins in ACLK; read results return via a poll frame.
module spi_axi_bridge_master #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 40,
  parameter int ID_WIDTH    = 1,
  parameter int WSTRB_WIDTH = 4,
  parameter int BLEN_WIDTH  = 5
) (
  input  logic                   ACLK,
  input  logic                   reset,
  input  logic                   SPI_SCLK,
  input  logic                   SPI_CS_N,
  input  logic                   SPI_MOSI,
  output logic                   SPI_MISO,
  output logic [ID_WIDTH-1:0]    AXI_AWID,
  output logic [ADDR_WIDTH-1:0]  AXI_AWADDR,
  output logic [BLEN_WIDTH-1:0]  AXI_AWLEN,
  output logic [2:0]             AXI_AWSIZE,
  output logic [1:0]             AXI_AWBURST,
  output logic [2:0]             AXI_AWPROT,
  output logic [3:0]             AXI_AWCACHE,
  output logic                   AXI_AWVALID,
  input  logic                   AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]  AXI_WDATA,
  output logic [WSTRB_WIDTH-1:0] AXI_WSTRB,
  output logic                   AXI_WLAST,
  output logic                   AXI_WVALID,
  input  logic                   AXI_WREADY,
  input  logic [1:0]             AXI_BRESP,
  input  logic                   AXI_BVALID,
  output logic                   AXI_BREADY,
  output logic [ID_WIDTH-1:0]    AXI_ARID,
  output logic [ADDR_WIDTH-1:0]  AXI_ARADDR,
  output logic [BLEN_WIDTH-1:0]  AXI_ARLEN,
  output logic [2:0]             AXI_ARSIZE,
  output logic [1:0]             AXI_ARBURST,
  output logic [2:0]             AXI_ARPROT,
  output logic [3:0]             AXI_ARCACHE,
  output logic                   AXI_ARVALID,
  input  logic                   AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]  AXI_RDATA,
  input  logic [1:0]             AXI_RRESP,
  input  logic                   AXI_RVALID,
  output logic                   AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R
  } state_t;

  localparam int RSP_W = DATA_WIDTH + 8;

  state_t state, state_n;

  logic [1:0] sclk_sy, cs_sy, mosi_sy;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall;
  logic       cs_rise, cs_act, mosi_s;

  logic [2:0]            bit_cnt;
  logic [3:0]            byte_cnt;
  logic [6:0]            sh;
  logic [7:0]            rx_byte;
  logic [7:0]            rx_op;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic [DATA_WIDTH-1:0] rx_data;

  logic [RSP_W-1:0] resp_sh;
  logic [5:0]       resp_cnt;
  logic             miso_q;
  logic             poll_latch;

  logic frame_ok, wr_frame, rd_frame, poll_frame;
  logic busy, accept, aw_ok, w_ok;

  logic                  aw_pend, w_pend;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  done, overrun, op_rd;
  logic [1:0]            resp;
  logic [DATA_WIDTH-1:0] rdata;
  logic [7:0]            status;

  always_ff @(posedge ACLK) begin
    if (reset) begin
      sclk_sy <= 2'b00;
      cs_sy   <= 2'b11;
      mosi_sy <= 2'b00;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
    end else begin
      sclk_sy <= {sclk_sy[0], SPI_SCLK};
      cs_sy   <= {cs_sy[0], SPI_CS_N};
      mosi_sy <= {mosi_sy[0], SPI_MOSI};
      sclk_d  <= sclk_sy[1];
      cs_d    <= cs_sy[1];
    end
  end

  assign sclk_rise = sclk_sy[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sy[1] & sclk_d;
  assign cs_rise   = cs_sy[1] & ~cs_d;
  assign cs_act    = ~cs_sy[1];
  assign mosi_s    = mosi_sy[1];
  assign rx_byte   = {sh, mosi_s};

  // Byte counter saturates so over-long frames never alias a valid length
  always_ff @(posedge ACLK) begin
    if (reset) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      rx_op    <= '0;
      rx_addr  <= '0;
      rx_data  <= '0;
    end else if (!cs_act) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (sclk_rise) begin
      sh      <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        if (byte_cnt != 4'hf)
          byte_cnt <= byte_cnt + 4'd1;
        if (byte_cnt == 4'd0)
          rx_op <= rx_byte;
        else if (byte_cnt <= 4'd5)
          rx_addr <= {rx_addr[ADDR_WIDTH-9:0], rx_byte};
        else if (byte_cnt <= 4'd9)
          rx_data <= {rx_data[DATA_WIDTH-9:0], rx_byte};
      end
    end
  end

  assign frame_ok   = cs_rise && (bit_cnt == 3'd0);
  assign wr_frame   = frame_ok && (rx_op == 8'h01)
                    && (byte_cnt == 4'd10);
  assign rd_frame   = frame_ok && (rx_op == 8'h02)
                    && (byte_cnt == 4'd6);
  assign poll_frame = frame_ok && (rx_op == 8'h03)
                    && (byte_cnt != 4'd0)
                    && (byte_cnt <= 4'd6);

  assign busy   = (state != IDLE);
  assign accept = (wr_frame || rd_frame) && !busy;
  assign aw_ok  = !aw_pend || AXI_AWREADY;
  assign w_ok   = !w_pend || AXI_WREADY;
  assign status = {done, busy, overrun, op_rd, 2'b00, resp};

  assign poll_latch = cs_act && sclk_rise
                   && (byte_cnt == 4'd0)
                   && (bit_cnt == 3'd7)
                   && (rx_byte == 8'h03);

  // Snapshot is frozen at the opcode's last bit; later completions don't touch it
  always_ff @(posedge ACLK) begin
    if (reset) begin
      resp_sh  <= '0;
      resp_cnt <= '0;
      miso_q   <= 1'b0;
    end else if (!cs_act) begin
      resp_cnt <= '0;
      miso_q   <= 1'b0;
    end else if (poll_latch) begin
      resp_sh  <= {status, rdata};
      resp_cnt <= 6'(RSP_W);
    end else if (sclk_fall) begin
      if (resp_cnt != 6'd0) begin
        miso_q   <= resp_sh[RSP_W-1];
        resp_sh  <= {resp_sh[RSP_W-2:0], 1'b0};
        resp_cnt <= resp_cnt - 6'd1;
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign SPI_MISO = miso_q;

  always_ff @(posedge ACLK) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    AXI_BREADY  = 1'b0;
    AXI_ARVALID = 1'b0;
    AXI_RREADY  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = wr_frame ? WR_AW_W : RD_AR;
      end
      WR_AW_W: begin
        if (aw_ok && w_ok)
          state_n = WR_B;
      end
      WR_B: begin
        AXI_BREADY = 1'b1;
        if (AXI_BVALID)
          state_n = IDLE;
      end
      RD_AR: begin
        AXI_ARVALID = 1'b1;
        if (AXI_ARREADY)
          state_n = RD_R;
      end
      RD_R: begin
        AXI_RREADY = 1'b1;
        if (AXI_RVALID)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      op_rd    <= 1'b0;
      resp     <= 2'b00;
      rdata    <= '0;
    end else begin
      if (accept) begin
        cmd_addr <= rx_addr;
        cmd_data <= rx_data;
        done     <= 1'b0;
        op_rd    <= rd_frame;
        aw_pend  <= wr_frame;
        w_pend   <= wr_frame;
      end else if (wr_frame || rd_frame) begin
        overrun <= 1'b1;
      end
      if (poll_frame)
        overrun <= 1'b0;
      if (aw_pend && AXI_AWREADY)
        aw_pend <= 1'b0;
      if (w_pend && AXI_WREADY)
        w_pend <= 1'b0;
      if (state == WR_B && AXI_BVALID) begin
        resp <= AXI_BRESP;
        done <= 1'b1;
      end
      if (state == RD_R && AXI_RVALID) begin
        rdata <= AXI_RDATA;
        resp  <= AXI_RRESP;
        done  <= 1'b1;
      end
    end
  end

  assign AXI_AWVALID = aw_pend;
  assign AXI_WVALID  = w_pend;
  assign AXI_AWADDR  = cmd_addr;
  assign AXI_ARADDR  = cmd_addr;
  assign AXI_WDATA   = cmd_data;

  assign AXI_AWID    = '0;
  assign AXI_ARID    = '0;
  assign AXI_AWLEN   = '0;
  assign AXI_ARLEN   = '0;
  assign AXI_AWSIZE  = 3'b010;
  assign AXI_ARSIZE  = 3'b010;
  assign AXI_AWBURST = 2'b01;
  assign AXI_ARBURST = 2'b01;
  assign AXI_AWPROT  = '0;
  assign AXI_ARPROT  = '0;
  assign AXI_AWCACHE = '0;
  assign AXI_ARCACHE = '0;
  assign AXI_WSTRB   = '1;
  assign AXI_WLAST   = 1'b1;

endmodule

// File: tb/tb_spi_axi_bridge_master.sv
// Bench for spi_axi_bridge_master: SPI master driver, AXI slave
// responder and a frame-level status/transaction model.
module tb_spi_axi_bridge_master;

  localparam int HALF = 60;

  logic ACLK = 0, reset = 1;
  logic SPI_SCLK = 0, SPI_CS_N = 1, SPI_MOSI = 0;
  logic SPI_MISO;
  logic [0:0]  AXI_AWID, AXI_ARID;
  logic [39:0] AXI_AWADDR, AXI_ARADDR;
  logic [4:0]  AXI_AWLEN, AXI_ARLEN;
  logic [2:0]  AXI_AWSIZE, AXI_ARSIZE, AXI_AWPROT, AXI_ARPROT;
  logic [1:0]  AXI_AWBURST, AXI_ARBURST;
  logic [3:0]  AXI_AWCACHE, AXI_ARCACHE, AXI_WSTRB;
  logic        AXI_AWVALID, AXI_AWREADY;
  logic [31:0] AXI_WDATA, AXI_RDATA;
  logic        AXI_WLAST, AXI_WVALID, AXI_WREADY;
  logic [1:0]  AXI_BRESP, AXI_RRESP;
  logic        AXI_BVALID, AXI_BREADY;
  logic        AXI_ARVALID, AXI_ARREADY;
  logic        AXI_RVALID, AXI_RREADY;

  spi_axi_bridge_master dut (
    .ACLK(ACLK), .reset(reset),
    .SPI_SCLK(SPI_SCLK), .SPI_CS_N(SPI_CS_N),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR),
    .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE),
    .AXI_AWBURST(AXI_AWBURST), .AXI_AWPROT(AXI_AWPROT),
    .AXI_AWCACHE(AXI_AWCACHE), .AXI_AWVALID(AXI_AWVALID),
    .AXI_AWREADY(AXI_AWREADY), .AXI_WDATA(AXI_WDATA),
    .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID),
    .AXI_BREADY(AXI_BREADY), .AXI_ARID(AXI_ARID),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARLEN(AXI_ARLEN),
    .AXI_ARSIZE(AXI_ARSIZE), .AXI_ARBURST(AXI_ARBURST),
    .AXI_ARPROT(AXI_ARPROT), .AXI_ARCACHE(AXI_ARCACHE),
    .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0, n_err = 0;

  // Model state
  logic        m_done = 0, m_busy = 0, m_ovr = 0, m_op = 0;
  logic [1:0]  m_resp = 0;
  logic [31:0] m_rdata = 0;
  logic [39:0] exp_aw_q[$], exp_ar_q[$];
  logic [31:0] exp_w_q[$];

  // Slave knobs and counters
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic b_hold = 0, ar_block = 0;
  int aw_w = 0, w_w = 0, ar_w = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int awv_cyc = 0, wv_cyc = 0, cs_hi = 0;
  logic aw_f = 0, w_f = 0, b_f = 0, ar_f = 0, r_f = 0;
  logic [39:0] last_aw = 0, last_ar = 0;
  logic [31:0] last_w = 0;

  logic [7:0] tx_buf[16];
  logic [7:0] rx_buf[16];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_done, m_busy, m_ovr, m_op, 2'b00, m_resp};
  endfunction

  function automatic void model_frame(input int nb, input int xb);
    logic [39:0] a;
    logic [31:0] d;
    if (xb != 0) return;
    a = {tx_buf[1], tx_buf[2], tx_buf[3], tx_buf[4], tx_buf[5]};
    d = {tx_buf[6], tx_buf[7], tx_buf[8], tx_buf[9]};
    if (tx_buf[0] == 8'h01 && nb == 10) begin
      if (m_busy) m_ovr = 1;
      else begin
        exp_aw_q.push_back(a);
        exp_w_q.push_back(d);
        m_busy = 1; m_done = 0; m_op = 0;
      end
    end else if (tx_buf[0] == 8'h02 && nb == 6) begin
      if (m_busy) m_ovr = 1;
      else begin
        exp_ar_q.push_back(a);
        m_busy = 1; m_done = 0; m_op = 1;
      end
    end else if (tx_buf[0] == 8'h03 && nb >= 1 && nb <= 6) begin
      m_ovr = 0;
    end
  endfunction

  // AXI slave responder and per-cycle compare against the model
  initial begin
    AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0;
    AXI_BVALID = 0; AXI_RVALID = 0;
    forever begin
      @(negedge ACLK);
      if (reset) begin
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0;
        AXI_BVALID = 0; AXI_RVALID = 0;
        aw_f = 0; w_f = 0; ar_f = 0; b_f = 0; r_f = 0;
        aw_w = 0; w_w = 0; ar_w = 0; cs_hi = 0;
      end else begin
        if (aw_f) begin
          aw_hs++;
          if (exp_aw_q.size() != 0) void'(exp_aw_q.pop_front());
        end
        if (w_f) begin
          w_hs++;
          if (exp_w_q.size() != 0) void'(exp_w_q.pop_front());
        end
        if (ar_f) begin
          ar_hs++;
          if (exp_ar_q.size() != 0) void'(exp_ar_q.pop_front());
        end
        if (b_f) begin
          b_hs++;
          m_busy = 0; m_done = 1; m_resp = AXI_BRESP;
        end
        if (r_f) begin
          r_hs++;
          m_busy = 0; m_done = 1;
          m_resp = AXI_RRESP; m_rdata = AXI_RDATA;
        end
        if (AXI_AWVALID) begin
          awv_cyc++;
          chk("aw_expected", 64'(exp_aw_q.size() != 0), 64'(1));
          if (exp_aw_q.size() != 0)
            chk("awaddr", 64'(AXI_AWADDR), 64'(exp_aw_q[0]));
          chk("awsize", 64'(AXI_AWSIZE), 64'(3'b010));
          chk("awburst", 64'(AXI_AWBURST), 64'(2'b01));
          chk("awlen", 64'(AXI_AWLEN), 64'(0));
        end
        if (AXI_WVALID) begin
          wv_cyc++;
          chk("w_expected", 64'(exp_w_q.size() != 0), 64'(1));
          if (exp_w_q.size() != 0)
            chk("wdata", 64'(AXI_WDATA), 64'(exp_w_q[0]));
          chk("wstrb", 64'(AXI_WSTRB), 64'(4'hf));
          chk("wlast", 64'(AXI_WLAST), 64'(1));
        end
        if (AXI_ARVALID) begin
          chk("ar_expected", 64'(exp_ar_q.size() != 0), 64'(1));
          if (exp_ar_q.size() != 0)
            chk("araddr", 64'(AXI_ARADDR), 64'(exp_ar_q[0]));
          chk("arsize", 64'(AXI_ARSIZE), 64'(3'b010));
          chk("arid", 64'(AXI_ARID), 64'(0));
        end
        if (SPI_CS_N) cs_hi++; else cs_hi = 0;
        if (cs_hi > 4) chk("miso_idle", 64'(SPI_MISO), 64'(0));
        AXI_AWREADY = AXI_AWVALID && (aw_w >= aw_dly);
        if (!AXI_AWVALID) aw_w = 0;
        else if (!AXI_AWREADY) aw_w++;
        AXI_WREADY = AXI_WVALID && (w_w >= w_dly);
        if (!AXI_WVALID) w_w = 0;
        else if (!AXI_WREADY) w_w++;
        AXI_ARREADY = AXI_ARVALID && !ar_block && (ar_w >= ar_dly);
        if (!AXI_ARVALID) ar_w = 0;
        else if (!AXI_ARREADY) ar_w++;
        AXI_BVALID = (((aw_hs < w_hs) ? aw_hs : w_hs) > b_hs) && !b_hold;
        AXI_RVALID = (ar_hs > r_hs);
        aw_f = AXI_AWVALID && AXI_AWREADY;
        w_f  = AXI_WVALID && AXI_WREADY;
        ar_f = AXI_ARVALID && AXI_ARREADY;
        b_f  = AXI_BVALID && AXI_BREADY;
        r_f  = AXI_RVALID && AXI_RREADY;
        if (aw_f) last_aw = AXI_AWADDR;
        if (w_f) last_w = AXI_WDATA;
        if (ar_f) last_ar = AXI_ARADDR;
      end
    end
  end

  task automatic spi_xfer(input int nb, input int xb);
    int bi, k;
    SPI_CS_N = 0;
    #HALF;
    for (int i = 0; i < nb * 8 + xb; i++) begin
      bi = i / 8;
      k = 7 - (i % 8);
      SPI_MOSI = tx_buf[bi][k];
      #HALF;
      SPI_SCLK = 1;
      rx_buf[bi][k] = SPI_MISO;
      #HALF;
      SPI_SCLK = 0;
    end
    #HALF;
    model_frame(nb, xb);
    SPI_CS_N = 1;
    SPI_MOSI = 0;
    #(HALF * 2);
  endtask

  task automatic send_wr(input logic [39:0] a, input logic [31:0] d);
    tx_buf[0] = 8'h01;
    for (int i = 0; i < 5; i++) tx_buf[1+i] = a[39-8*i -: 8];
    for (int i = 0; i < 4; i++) tx_buf[6+i] = d[31-8*i -: 8];
    spi_xfer(10, 0);
  endtask

  task automatic send_rd(input logic [39:0] a);
    tx_buf[0] = 8'h02;
    for (int i = 0; i < 5; i++) tx_buf[1+i] = a[39-8*i -: 8];
    spi_xfer(6, 0);
  endtask

  task automatic do_poll(output logic [39:0] got);
    logic [39:0] exp;
    exp = {m_status(), m_rdata};
    tx_buf[0] = 8'h03;
    for (int i = 1; i < 6; i++) tx_buf[i] = 8'($urandom);
    spi_xfer(6, 0);
    got = {rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4], rx_buf[5]};
    chk("poll_vs_model", 64'(got), 64'(exp));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_busy || exp_aw_q.size() != 0 || exp_w_q.size() != 0
            || exp_ar_q.size() != 0) && k < 500) begin
      @(negedge ACLK);
      k++;
    end
    chk("idle_timeout", 64'(k < 500), 64'(1));
    repeat (4) @(negedge ACLK);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] got;
    int hs0, bs0, nb, xb;
    AXI_BRESP = 0; AXI_RRESP = 0; AXI_RDATA = 0;
    repeat (4) @(negedge ACLK);
    chk("rst_awvalid", 64'(AXI_AWVALID), 64'(0));
    chk("rst_wvalid", 64'(AXI_WVALID), 64'(0));
    chk("rst_bready", 64'(AXI_BREADY), 64'(0));
    chk("rst_arvalid", 64'(AXI_ARVALID), 64'(0));
    chk("rst_rready", 64'(AXI_RREADY), 64'(0));
    chk("rst_miso", 64'(SPI_MISO), 64'(0));
    #2 reset = 0;
    repeat (4) @(negedge ACLK);
    #2;

    hs0 = aw_hs; bs0 = b_hs;
    send_wr(40'h0000001000, 32'hDEADBEEF);
    wait_idle();
    chk("wr_awaddr", 64'(last_aw), 64'h0000001000);
    chk("wr_wdata", 64'(last_w), 64'hDEADBEEF);
    chk("wr_aw_beats", 64'(aw_hs - hs0), 64'(1));
    chk("wr_b_beats", 64'(b_hs - bs0), 64'(1));
    do_poll(got);
    chk("wr_status", 64'(got[39:32]), 64'h80);

    AXI_RDATA = 32'hCAFEF00D; AXI_RRESP = 2'd2;
    send_rd(40'h123456789C);
    wait_idle();
    chk("rd_araddr", 64'(last_ar), 64'h123456789C);
    do_poll(got);
    chk("rd_poll", 64'(got), 64'h92CAFEF00D);

    aw_dly = 0; w_dly = 5;
    awv_cyc = 0; wv_cyc = 0; bs0 = b_hs;
    send_wr(40'hA5_0000_0040, 32'h01234567);
    wait_idle();
    chk("dly_awvalid_cyc", 64'(awv_cyc), 64'(1));
    chk("dly_wvalid_cyc", 64'(wv_cyc), 64'(6));
    chk("dly_b_beats", 64'(b_hs - bs0), 64'(1));
    w_dly = 0;

    hs0 = aw_hs;
    b_hold = 1;
    send_wr(40'h00_0000_0100, 32'h11111111);
    repeat (30) @(negedge ACLK);
    #2;
    send_wr(40'h00_0000_0200, 32'h22222222);
    repeat (30) @(negedge ACLK);
    #2;
    do_poll(got);
    chk("ovr_status", 64'(got[39:32]), 64'h60);
    b_hold = 0;
    wait_idle();
    #2;
    do_poll(got);
    chk("ovr_after_b", 64'(got[39:32]), 64'h80);
    chk("ovr_aw_beats", 64'(aw_hs - hs0), 64'(1));

    hs0 = aw_hs + ar_hs;
    send_wr(40'h00_0000_0300, 32'h33333333);
    wait_idle();
    #2;
    tx_buf[0] = 8'h01;
    spi_xfer(7, 0);
    tx_buf[0] = 8'h7F;
    spi_xfer(10, 0);
    tx_buf[0] = 8'h01;
    spi_xfer(9, 3);
    spi_xfer(11, 0);
    repeat (20) @(negedge ACLK);
    #2;
    chk("bad_no_axi", 64'(aw_hs + ar_hs - hs0), 64'(1));
    do_poll(got);
    chk("bad_status", 64'(got[39:32]), 64'h80);

    for (int it = 0; it < 24; it++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      AXI_BRESP = 2'($urandom);
      AXI_RRESP = 2'($urandom);
      AXI_RDATA = $urandom;
      case ($urandom_range(0, 3))
        0: send_wr({8'($urandom), 32'($urandom)}, $urandom);
        1: send_rd({8'($urandom), 32'($urandom)});
        2: begin
          for (int i = 0; i < 16; i++) tx_buf[i] = 8'($urandom);
          xb = 0;
          case ($urandom_range(0, 2))
            0: begin
              tx_buf[0] = 8'h01;
              nb = $urandom_range(1, 9);
            end
            1: begin
              tx_buf[0] = 8'($urandom_range(4, 255));
              nb = 10;
            end
            default: begin
              tx_buf[0] = 8'h02;
              nb = 5;
              xb = $urandom_range(1, 7);
            end
          endcase
          spi_xfer(nb, xb);
        end
        default: ;
      endcase
      wait_idle();
      #2;
      do_poll(got);
    end

    ar_block = 1;
    send_rd(40'h00_DEAD_0000);
    begin
      int k;
      k = 0;
      while (!AXI_ARVALID && k < 100) begin
        @(negedge ACLK);
        k++;
      end
      chk("rst_arvalid_seen", 64'(AXI_ARVALID), 64'(1));
    end
    @(negedge ACLK);
    #1 reset = 1;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    m_done = 0; m_busy = 0; m_ovr = 0; m_op = 0;
    m_resp = 0; m_rdata = 0;
    @(negedge ACLK);
    chk("rst_mid_arvalid", 64'(AXI_ARVALID), 64'(0));
    chk("rst_mid_rready", 64'(AXI_RREADY), 64'(0));
    @(negedge ACLK);
    #1 reset = 0;
    ar_block = 0;
    repeat (4) @(negedge ACLK);
    #2;
    do_poll(got);
    chk("rst_poll", 64'(got), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
